// File: rtl/mem_arbiter.sv
// Shares one multi-cycle chip-select/stall memory port between the fetch (I)
// and load/store (D) paths with alternating priority and a BUSY watchdog.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_stall,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_stall,
    output logic                  m_cs,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic                  m_stall,
    output logic                  timeout_err,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef enum logic {
        G_I = 1'b0,
        G_D = 1'b1
    } grant_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t                state_q, state_d;
    grant_t                grant_q, grant_d;
    grant_t                last_grant_q, last_grant_d;
    grant_t                winner;
    logic [7:0]            cnt_q, cnt_d;
    logic                  m_cs_q, m_cs_d;
    logic                  m_we_q, m_we_d;
    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            grant_q       <= G_I;
            last_grant_q  <= G_I;
            cnt_q         <= '0;
            m_cs_q        <= 1'b0;
            m_we_q        <= 1'b0;
            m_addr_q      <= '0;
            m_wdata_q     <= '0;
            i_rdata_q     <= '0;
            d_rdata_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            m_cs_q        <= m_cs_d;
            m_we_q        <= m_we_d;
            m_addr_q      <= m_addr_d;
            m_wdata_q     <= m_wdata_d;
            i_rdata_q     <= i_rdata_d;
            d_rdata_q     <= d_rdata_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // D wins contention unless it won the previous grant.
    always_comb begin
        winner = G_I;
        if (d_req && !(i_req && last_grant_q == G_D)) begin
            winner = G_D;
        end
    end

    // The first BUSY cycle never completes: the memory is still sampling the address.
    assign done = (cnt_q != 8'd0) && !m_stall;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        m_cs_d        = m_cs_q;
        m_we_d        = m_we_q;
        m_addr_d      = m_addr_q;
        m_wdata_d     = m_wdata_q;
        i_rdata_d     = i_rdata_q;
        d_rdata_d     = d_rdata_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            S_IDLE: begin
                if (i_req || d_req) begin
                    state_d      = S_BUSY;
                    grant_d      = winner;
                    last_grant_d = winner;
                    cnt_d        = 8'd0;
                    m_cs_d       = 1'b1;
                    if (winner == G_D) begin
                        m_we_d    = d_we;
                        m_addr_d  = d_addr;
                        m_wdata_d = d_wdata;
                    end else begin
                        m_we_d    = 1'b0;
                        m_addr_d  = i_addr;
                        m_wdata_d = '0;
                    end
                end
            end

            S_BUSY: begin
                cnt_d = cnt_q + 8'd1;
                if (done) begin
                    state_d = S_RESP;
                    m_cs_d  = 1'b0;
                    m_we_d  = 1'b0;
                    if (grant_q == G_D) begin
                        d_rdata_d = m_rdata;
                    end else begin
                        i_rdata_d = m_rdata;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d       = S_RESP;
                    m_cs_d        = 1'b0;
                    m_we_d        = 1'b0;
                    timeout_err_d = 1'b1;
                    if (grant_q == G_D) begin
                        d_rdata_d = '0;
                    end else begin
                        i_rdata_d = '0;
                    end
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake: a requester raises req with stable inputs and holds it until
    // the single cycle its stall is low; it advances on the following edge.
    assign i_stall = i_req & ~(state_q == S_RESP && grant_q == G_I);
    assign d_stall = d_req & ~(state_q == S_RESP && grant_q == G_D);

    assign i_rdata     = i_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign m_cs        = m_cs_q;
    assign m_we        = m_we_q;
    assign m_addr      = m_addr_q;
    assign m_wdata     = m_wdata_q;
    assign timeout_err = timeout_err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural stall/latency memory model, per-port
// expected-data queues popped on each completion beat, one task per scenario.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] i_rdata, d_rdata;
    logic          i_stall, d_stall;
    logic          m_cs, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic          m_stall;
    logic          timeout_err;
    logic [1:0]    dbg_state;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [DW-1:0] i_exp_q[$];
    logic [DW-1:0] d_exp_q[$];
    int            served_q[$];
    logic [DW-1:0] mon_exp;

    int            mem_lat   = 3;
    bit            mem_stuck = 1'b0;
    bit            fixed_en  = 1'b0;
    logic [DW-1:0] fixed_data = '0;
    int            mem_cnt   = 0;
    logic [DW-1:0] last_wr_data = '0;
    logic [AW-1:0] last_wr_addr = '0;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_stall(d_stall),
        .m_cs(m_cs), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_stall(m_stall),
        .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    // ---------------- memory model ----------------
    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return {a[15:0], a[15:0]} ^ 32'hC0DE_1234;
    endfunction

    assign m_rdata = fixed_en ? fixed_data : mem_fn(m_addr);
    assign m_stall = mem_stuck ? 1'b1 : (mem_cnt < mem_lat - 1);

    always @(posedge clk) begin
        if (!m_cs) mem_cnt <= 0;
        else       mem_cnt <= mem_cnt + 1;
        if (m_cs && m_we && !m_stall) begin
            last_wr_addr <= m_addr;
            last_wr_data <= m_wdata;
        end
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (i_req && !i_stall) begin
                served_q.push_back(0);
                chk_cnt++;
                if (i_exp_q.size() == 0) begin
                    $display("FAIL i_scoreboard: unexpected response i_rdata=%h, want no response", i_rdata);
                end else begin
                    mon_exp = i_exp_q.pop_front();
                    if (i_rdata !== mon_exp) $display("FAIL i_scoreboard: i_rdata=%h want %h", i_rdata, mon_exp);
                    else pass_cnt++;
                end
            end
            if (d_req && !d_stall) begin
                served_q.push_back(1);
                chk_cnt++;
                if (d_exp_q.size() == 0) begin
                    $display("FAIL d_scoreboard: unexpected response d_rdata=%h, want no response", d_rdata);
                end else begin
                    mon_exp = d_exp_q.pop_front();
                    if (d_rdata !== mon_exp) $display("FAIL d_scoreboard: d_rdata=%h want %h", d_rdata, mon_exp);
                    else pass_cnt++;
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_stall_low(input bit port_d, input int budget, output int cycles);
        cycles = -1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if ((port_d ? d_stall : i_stall) === 1'b0) begin
                cycles = n;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0; i_req = 1'b1; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_cnt++; if (m_cs !== 1'b0) $display("FAIL reset_m_cs: got %b want 0", m_cs); else pass_cnt++;
        chk_cnt++; if (i_rdata !== '0) $display("FAIL reset_i_rdata: got %h want 0", i_rdata); else pass_cnt++;
        chk_cnt++; if (d_rdata !== '0) $display("FAIL reset_d_rdata: got %h want 0", d_rdata); else pass_cnt++;
        chk_cnt++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err: got %b want 0", timeout_err); else pass_cnt++;
        chk_cnt++; if (i_stall !== 1'b1) $display("FAIL reset_i_stall: got %b want 1", i_stall); else pass_cnt++;
        chk_cnt++; if (d_stall !== 1'b0) $display("FAIL reset_d_stall: got %b want 0", d_stall); else pass_cnt++;
        @(posedge clk); #1;
        i_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk_cnt++; if (dbg_state !== 2'd0 || m_cs !== 1'b0)
            $display("FAIL reset_release_idle: state=%0d m_cs=%b want 0/0", dbg_state, m_cs); else pass_cnt++;
    endtask

    task automatic test_single_fetch();
        int cycles, cs_cyc, bad;
        fixed_en = 1'b1; fixed_data = 32'h2402000A; mem_lat = 7;
        @(posedge clk); #1;
        i_addr = 32'h4; i_req = 1'b1;
        i_exp_q.push_back(32'h2402000A);
        cycles = -1; cs_cyc = 0; bad = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (m_cs) begin
                cs_cyc++;
                if (m_addr !== 32'h4 || m_we !== 1'b0 || m_wdata !== '0) bad++;
            end
            if (!i_stall) begin cycles = n; break; end
        end
        chk_cnt++; if (cycles != 9) $display("FAIL fetch_latency: got %0d want 9", cycles); else pass_cnt++;
        chk_cnt++; if (cs_cyc != 7) $display("FAIL fetch_cs_cycles: got %0d want 7", cs_cyc); else pass_cnt++;
        chk_cnt++; if (bad != 0) $display("FAIL fetch_m_stable: got %0d unstable cycles want 0", bad); else pass_cnt++;
        chk_cnt++; if (i_rdata !== 32'h2402000A) $display("FAIL fetch_rdata: got %h want 2402000a", i_rdata); else pass_cnt++;
        @(posedge clk); #1;
        i_req = 1'b0;
        @(negedge clk);
        chk_cnt++; if (dbg_state !== 2'd0 || m_cs !== 1'b0)
            $display("FAIL fetch_back_idle: state=%0d m_cs=%b want 0/0", dbg_state, m_cs); else pass_cnt++;
        fixed_en = 1'b0;
        @(negedge clk);
        chk_cnt++; if (i_rdata !== 32'h2402000A) $display("FAIL fetch_rdata_hold: got %h want 2402000a", i_rdata); else pass_cnt++;
    endtask

    task automatic test_contention();
        int exp_order[4];
        int low_run, min_gap;
        bit seen_hi;
        exp_order = '{1, 0, 1, 0};
        mem_lat = 3;
        served_q.delete();
        low_run = 0; min_gap = 1000; seen_hi = 1'b0;
        @(posedge clk); #1;
        i_addr = 32'h100; d_addr = 32'h200; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            d_exp_q.push_back(mem_fn(32'h200));
            i_exp_q.push_back(mem_fn(32'h100));
        end
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (m_cs) begin
                if (seen_hi && low_run > 0 && low_run < min_gap) min_gap = low_run;
                seen_hi = 1'b1; low_run = 0;
            end else begin
                low_run++;
            end
            #1;
            if (served_q.size() >= 4) break;
        end
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
        chk_cnt++; if (served_q.size() != 4) $display("FAIL contention_count: got %0d want 4", served_q.size()); else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            chk_cnt++;
            if (k >= served_q.size() || served_q[k] != exp_order[k])
                $display("FAIL contention_order[%0d]: got %0d want %0d (1=D 0=I)", k,
                         (k < served_q.size()) ? served_q[k] : -1, exp_order[k]);
            else pass_cnt++;
        end
        chk_cnt++; if (min_gap < 2 || min_gap == 1000)
            $display("FAIL contention_cs_gap: got %0d want >=2", min_gap); else pass_cnt++;
    endtask

    task automatic test_store();
        int cycles, busy, bad;
        mem_lat = 4;
        @(posedge clk); #1;
        d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF; d_req = 1'b1; i_req = 1'b0;
        d_exp_q.push_back(mem_fn(32'h10));
        cycles = -1; busy = 0; bad = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (m_cs) begin
                busy++;
                if (m_we !== 1'b1 || m_wdata !== 32'hDEADBEEF || m_addr !== 32'h10) bad++;
                if (busy == 1) d_wdata = 32'h0;
            end
            if (!d_stall) begin
                cycles = n;
                chk_cnt++; if (m_we !== 1'b0 || m_cs !== 1'b0)
                    $display("FAIL store_resp_m: m_we=%b m_cs=%b want 0/0", m_we, m_cs); else pass_cnt++;
                chk_cnt++; if (i_stall !== 1'b0) $display("FAIL store_i_stall: got %b want 0", i_stall); else pass_cnt++;
                break;
            end
        end
        @(posedge clk); #1;
        d_req = 1'b0; d_we = 1'b0;
        chk_cnt++; if (cycles != 6) $display("FAIL store_latency: got %0d want 6", cycles); else pass_cnt++;
        chk_cnt++; if (busy != 4) $display("FAIL store_busy_cycles: got %0d want 4", busy); else pass_cnt++;
        chk_cnt++; if (bad != 0) $display("FAIL store_m_stable: got %0d unstable cycles want 0", bad); else pass_cnt++;
        chk_cnt++; if (last_wr_data !== 32'hDEADBEEF || last_wr_addr !== 32'h10)
            $display("FAIL store_mem_write: got %h@%h want deadbeef@10", last_wr_data, last_wr_addr); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int cycles;
        mem_stuck = 1'b1;
        @(posedge clk); #1;
        d_addr = 32'h20; d_we = 1'b0; d_req = 1'b1;
        d_exp_q.push_back('0);
        wait_stall_low(1'b1, 40, cycles);
        chk_cnt++; if (cycles != TO + 2) $display("FAIL timeout_latency: got %0d want %0d", cycles, TO + 2); else pass_cnt++;
        chk_cnt++; if (d_rdata !== '0) $display("FAIL timeout_rdata: got %h want 0", d_rdata); else pass_cnt++;
        chk_cnt++; if (timeout_err !== 1'b1) $display("FAIL timeout_flag: got %b want 1", timeout_err); else pass_cnt++;
        @(posedge clk); #1;
        d_req = 1'b0; mem_stuck = 1'b0; mem_lat = 2;
        i_addr = 32'h30; i_req = 1'b1;
        i_exp_q.push_back(mem_fn(32'h30));
        wait_stall_low(1'b0, 40, cycles);
        chk_cnt++; if (cycles != 4) $display("FAIL after_timeout_latency: got %0d want 4", cycles); else pass_cnt++;
        chk_cnt++; if (timeout_err !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", timeout_err); else pass_cnt++;
        @(posedge clk); #1;
        i_req = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        int cycles;
        mem_lat = 4;
        @(posedge clk); #1;
        d_addr = 32'h40; d_we = 1'b0; d_req = 1'b1;
        d_exp_q.push_back(mem_fn(32'h40));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_cnt++; if (dbg_state !== 2'd1 || m_cs !== 1'b1)
            $display("FAIL midbusy_pre: state=%0d m_cs=%b want 1/1", dbg_state, m_cs); else pass_cnt++;
        rst = 1'b0;
        #1;
        chk_cnt++; if (m_cs !== 1'b0 || m_addr !== '0) $display("FAIL midbusy_m_cs: m_cs=%b m_addr=%h want 0/0", m_cs, m_addr); else pass_cnt++;
        chk_cnt++; if (dbg_state !== 2'd0) $display("FAIL midbusy_state: got %0d want 0", dbg_state); else pass_cnt++;
        chk_cnt++; if (d_rdata !== '0) $display("FAIL midbusy_rdata: got %h want 0", d_rdata); else pass_cnt++;
        chk_cnt++; if (timeout_err !== 1'b0) $display("FAIL midbusy_timeout_clr: got %b want 0", timeout_err); else pass_cnt++;
        chk_cnt++; if (d_stall !== 1'b1) $display("FAIL midbusy_d_stall: got %b want 1", d_stall); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b1;
        wait_stall_low(1'b1, 40, cycles);
        chk_cnt++; if (cycles != 6) $display("FAIL midbusy_rearb_latency: got %0d want 6", cycles); else pass_cnt++;
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_store();
        test_timeout();
        test_reset_mid_busy();
        repeat (2) @(negedge clk);
        chk_cnt++; if (i_exp_q.size() != 0) $display("FAIL i_queue_drained: got %0d left want 0", i_exp_q.size()); else pass_cnt++;
        chk_cnt++; if (d_exp_q.size() != 0) $display("FAIL d_queue_drained: got %0d left want 0", d_exp_q.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one slow, multi-cycle memory port between the CPU instruction-fetch path and the data (load/store) path. It sits between the pipeline and the backing memory, which uses a chip-select/stall handshake. The arbiter holds address, write-enable and write data stable for the whole access, returns registered read data, and stalls the losing requester. A watchdog aborts accesses that never complete.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- TIMEOUT, 15, max BUSY cycles before abort (1..255)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- i_req  in  1  instruction fetch request, held until i_stall low
- i_addr  in  ADDR_WIDTH  fetch address
- i_rdata  out  DATA_WIDTH  fetched word, registered
- i_stall  out  1  fetch not yet complete
- d_req  in  1  data access request, held until d_stall low
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_rdata  out  DATA_WIDTH  load data, registered
- d_stall  out  1  data access not yet complete
- m_cs  out  1  memory select, registered
- m_we  out  1  memory write enable, registered
- m_addr  out  ADDR_WIDTH  memory address, registered
- m_wdata  out  DATA_WIDTH  memory write data, registered
- m_rdata  in  DATA_WIDTH  memory read data
- m_stall  in  1  memory busy (meaningful only while m_cs=1)
- timeout_err  out  1  sticky watchdog flag

## Operation
- States: IDLE, BUSY, RESP. Register grant (I or D) and last_grant (I or D).
- IDLE, arbitration:
  - only one request pending: grant it;
  - both pending: grant D, unless last_grant=D, then grant I (alternation under contention);
  - neither pending: stay in IDLE.
- IDLE -> BUSY on grant: latch m_addr/m_we/m_wdata from the granted port. For the I port, m_we=0 and m_wdata=0. Set m_cs=1, clear the wait counter, and set last_grant to the winner.
- BUSY: m_* held constant. The wait counter increments every cycle.
  - m_stall is ignored in the first BUSY cycle, because the memory has not yet seen the new address.
  - From the second BUSY cycle on, m_stall=0 means complete: capture m_rdata into the granted port's rdata register (also on writes), then go to RESP.
  - If the counter reaches TIMEOUT without completion: abort. Load the granted port's rdata register with 0, set timeout_err, go to RESP.
- RESP: m_cs=0 and m_we=0. Next state is always IDLE.
- Stalls are combinational:
  - i_stall = i_req & ~(state==RESP & grant==I)
  - d_stall = d_req & ~(state==RESP & grant==D)
- Requests withdrawn mid-access do not abort it. The access completes and rdata is updated.
- timeout_err stays set until reset. It does not block further accesses.
- Reset (rst=0, immediate): state IDLE, grant=I, last_grant=I. m_cs, m_we, m_addr, m_wdata, i_rdata, d_rdata, timeout_err and the counter all go to 0. While in reset, the stalls equal their reqs.

## Timing
- Access latency, from the request first seen in IDLE to the stall dropping, is L+2 cycles, where L is the number of BUSY cycles. L is at least 2.
- The stall is low for exactly one cycle, in RESP. The requester advances on the following edge.
- Back-to-back accesses have at least one IDLE cycle between RESP and the next BUSY. m_cs drops for at least 2 cycles between accesses, which forces the memory to re-sample the address.
- Abort occurs after exactly TIMEOUT BUSY cycles, so the stall drops at cycle TIMEOUT+2.
- rdata registers change only on the completion/abort edge. They hold their value otherwise.

## Test plan
- Reset: rst=0 during activity with i_req=1 -> m_cs=0, i_rdata=0, timeout_err=0, i_stall=1; deassert rst, IDLE next cycle.
- Single fetch: i_req=1, i_addr=0x4, memory model drops m_stall after 7 BUSY cycles with data 0x2402000A -> m_cs=1 for 7 cycles, m_addr=0x4 stable, i_stall low one cycle, i_rdata=0x2402000A.
- Contention: i_req and d_req both held, last_grant=I -> D served first, then I. Repeat with both pending -> order alternates D, I, D, I.
- Store: d_req=1, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF -> m_we=1, m_wdata=0xDEADBEEF held through BUSY; m_we=0 in RESP; i_stall unaffected when i_req=0.
- Timeout: m_stall stuck 1, TIMEOUT=15, d_req read -> d_stall drops at cycle 17, d_rdata=0, timeout_err=1. It stays 1 across the next, successful access until reset.
- Reset mid-BUSY: assert rst=0 in the 3rd BUSY cycle -> m_cs=0 immediately, no rdata update. After release, the pending request is re-arbitrated from IDLE.
